// File: rtl/shift_pkg.sv
// ============================================================================
// shift_pkg : shared shifter types, widths and bit-reversal helper
// Revision  : 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_op_t;

    localparam int SHIFT_DATA_W = 64;
    localparam int SHIFT_AMT_W  = 6;

    function automatic logic [SHIFT_DATA_W-1:0] bit_rev(input logic [SHIFT_DATA_W-1:0] v);
        logic [SHIFT_DATA_W-1:0] r;
        for (int i = 0; i < SHIFT_DATA_W; i++) begin
            r[i] = v[SHIFT_DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_core.sv
// ============================================================================
// shift_core : combinational 64-bit shifter (LSL/LSR/ASR[/ROR]) on one left core
// Optional macro SHIFT_ARB_ROR_EN enables rotate-right; otherwise op 3 = LSL.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module shift_core
    import shift_pkg::*;
(
    input  logic [SHIFT_DATA_W-1:0] data,
    input  logic [SHIFT_AMT_W-1:0]  shamt,
    input  logic [1:0]              op,
    output logic [SHIFT_DATA_W-1:0] result
);

    logic                    is_right;
    logic [SHIFT_DATA_W-1:0] pre;
    logic [SHIFT_DATA_W-1:0] shl;
    logic [SHIFT_DATA_W-1:0] base;
    logic [SHIFT_DATA_W-1:0] fill;
    logic [SHIFT_DATA_W-1:0] rot_hi;
`ifdef SHIFT_ARB_ROR_EN
    logic [SHIFT_AMT_W:0]    ror_amt;
`endif

    always_comb begin
`ifdef SHIFT_ARB_ROR_EN
        is_right = (op == SH_LSR) || (op == SH_ASR) || (op == SH_ROR);
`else
        is_right = (op == SH_LSR) || (op == SH_ASR);
`endif
        pre = is_right ? bit_rev(data) : data;

        // Six binary-weighted mux stages
        shl = pre;
        for (int k = 0; k < SHIFT_AMT_W; k++) begin
            if (shamt[k]) begin
                shl = shl << (1 << k);
            end
        end

        base = is_right ? bit_rev(shl) : shl;

        // Top shamt bits set, used as the sign fill for ASR
        fill = '0;
        if ((op == SH_ASR) && data[SHIFT_DATA_W-1]) begin
            fill = bit_rev(~({SHIFT_DATA_W{1'b1}} << shamt));
        end

        rot_hi = '0;
`ifdef SHIFT_ARB_ROR_EN
        // shamt==0 gives a shift by 64, which yields zero and leaves data intact
        ror_amt = (SHIFT_AMT_W+1)'(SHIFT_DATA_W) - {1'b0, shamt};
        if (op == SH_ROR) begin
            rot_hi = data << ror_amt;
        end
`endif
        result = base | fill | rot_hi;
    end

endmodule

`default_nettype wire

// File: rtl/shift_arbiter.sv
// ============================================================================
// shift_arbiter : round-robin arbiter sharing one shift_core, registered result
// Optional macro SHIFT_ARB_ROR_EN (passed through to shift_core).
// Revision      : 1.0
// ============================================================================
`default_nettype none

module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*SHIFT_DATA_W-1:0] req_data,
    input  logic [NUM_REQ*SHIFT_AMT_W-1:0]  req_shamt,
    input  logic [NUM_REQ*2-1:0]            req_op,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [SHIFT_DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]                 rsp_id
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  state;
    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         winner;
    logic                    found;
    logic                    can_accept;
    logic                    accept;
    int                      idx;
    logic [SHIFT_DATA_W-1:0] sel_data;
    logic [SHIFT_AMT_W-1:0]  sel_shamt;
    logic [1:0]              sel_op;
    logic [SHIFT_DATA_W-1:0] shift_res;

    assign can_accept = (state == IDLE) || rsp_ready;

    // First valid requester at or above rr_ptr, wrapping around
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // Gated by reset_n so the grant is all zero while reset is held
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = reset_n && found && can_accept && (winner == ID_W'(i));
        end
    end

    assign accept    = |(req_valid & req_ready);
    assign sel_data  = req_data[int'(winner)*SHIFT_DATA_W +: SHIFT_DATA_W];
    assign sel_shamt = req_shamt[int'(winner)*SHIFT_AMT_W +: SHIFT_AMT_W];
    assign sel_op    = req_op[int'(winner)*2 +: 2];

    shift_core u_core (
        .data   (sel_data),
        .shamt  (sel_shamt),
        .op     (sel_op),
        .result (shift_res)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else if (accept) begin
            state     <= HOLD;
            rsp_valid <= 1'b1;
            rsp_data  <= shift_res;
            rsp_id    <= winner;
            rr_ptr    <= (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);
        end else if ((state == HOLD) && rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// ============================================================================
// tb_shift_arbiter : vector table, directed handshake sequences, random vs model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_shift_arbiter;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*64-1:0]  req_data;
    logic [N*6-1:0]   req_shamt;
    logic [N*2-1:0]   req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_data;
    logic [ID_W-1:0]  rsp_id;

    int checks   = 0;
    int failures = 0;

    shift_arbiter #(.NUM_REQ(N), .ID_W(ID_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shamt (req_shamt),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [63:0] d;
        int          s;
        int          op;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    // Reference model state
    bit          m_hold;
    logic [63:0] m_data;
    int          m_id;
    int          m_ptr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_shift(input logic [63:0] d, input int s, input int op);
        case (op)
            0: return d << s;
            1: return d >> s;
            2: return 64'($signed(d) >>> s);
            default: begin
`ifdef SHIFT_ARB_ROR_EN
                if (s == 0) return d;
                return (d >> s) | (d << (64 - s));
`else
                return d << s;
`endif
            end
        endcase
    endfunction

    function automatic int model_winner(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [63:0] d, input int s, input int op);
        req_valid[i]         = 1'b1;
        req_data[i*64 +: 64] = d;
        req_shamt[i*6 +: 6]  = 6'(s);
        req_op[i*2 +: 2]     = 2'(op);
    endtask

    initial begin
        logic [63:0] held_data;
        logic [63:0] d3;
        int          w;
        logic [N-1:0] exp_ready;

        vecs[0] = '{0, 64'd455, 6, 0, 64'd29120};
        vecs[1] = '{1, 64'h8000_0000_0000_0000, 63, 1, 64'h1};
        vecs[2] = '{2, 64'h8000_0000_0000_0000, 63, 2, 64'hFFFF_FFFF_FFFF_FFFF};
`ifdef SHIFT_ARB_ROR_EN
        vecs[3] = '{3, 64'h1, 1, 3, 64'h8000_0000_0000_0000};
        vecs[7] = '{3, 64'h0123_4567_89AB_CDEF, 8, 3, 64'hEF01_2345_6789_ABCD};
`else
        vecs[3] = '{3, 64'h1, 1, 3, 64'h2};
        vecs[7] = '{3, 64'h0123_4567_89AB_CDEF, 8, 3, 64'h2345_6789_ABCD_EF00};
`endif
        vecs[4] = '{2, 64'h0123_4567_89AB_CDEF, 4, 1, 64'h0012_3456_789A_BCDE};
        vecs[5] = '{1, 64'hF000_0000_0000_0000, 4, 2, 64'hFF00_0000_0000_0000};
        vecs[6] = '{0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 2, 64'h7FFF_FFFF_FFFF_FFFF};

        // Reset with busy inputs
        reset_n   = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        req_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        req_shamt = 24'($urandom);
        req_op    = 8'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'h0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("reset_rsp_data", rsp_data, 64'h0);
        chk("reset_rsp_id", 64'(rsp_id), 64'h0);
        @(posedge clk); #1;
        reset_n   = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("idle_req_ready", 64'(req_ready), 64'h0);
        chk("idle_rsp_valid", 64'(rsp_valid), 64'h0);

        // Table of single-requester vectors, back-to-back
        for (int v = 0; v < 8; v++) begin
            req_valid = '0;
            set_req(vecs[v].id, vecs[v].d, vecs[v].s, vecs[v].op);
            #1;
            chk($sformatf("vec%0d_ready", v), 64'(req_ready), 64'(1) << vecs[v].id);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", v), 64'(rsp_valid), 64'h1);
            chk($sformatf("vec%0d_data", v), rsp_data, vecs[v].exp);
            chk($sformatf("vec%0d_id", v), 64'(rsp_id), 64'(vecs[v].id));
        end

        // Drain, then backpressure while holding
        req_valid = '0;
        @(posedge clk); #1;
        chk("drain_valid", 64'(rsp_valid), 64'h0);
        rsp_ready = 1'b0;
        set_req(2, 64'h00FF, 4, 0);
        @(posedge clk); #1;
        chk("bp_first_valid", 64'(rsp_valid), 64'h1);
        chk("bp_first_id", 64'(rsp_id), 64'h2);
        chk("bp_first_data", rsp_data, 64'h0FF0);
        held_data = rsp_data;
        d3 = 64'hDEAD_BEEF_0000_0001;
        for (int i = 0; i < N; i++) set_req(i, d3 + 64'(i), 1, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready_low", 64'(req_ready), 64'h0);
            @(posedge clk); #1;
            chk("bp_data_stable", rsp_data, held_data);
            chk("bp_id_stable", 64'(rsp_id), 64'h2);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(req_ready), 64'h8);
        @(posedge clk); #1;
        chk("bp_release_id", 64'(rsp_id), 64'h3);
        chk("bp_release_data", rsp_data, (d3 + 64'd3) << 1);

        // Move the pointer off zero, hold a result, then reset asynchronously
        req_valid = '0;
        set_req(1, 64'h5, 0, 0);
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        chk("hold_before_reset", 64'(rsp_valid), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_valid", 64'(rsp_valid), 64'h0);
        chk("async_reset_data", rsp_data, 64'h0);
        @(posedge clk); #1;
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 64'(i + 1), i, 0);

        // Round robin from a fresh pointer
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("rr%0d_ready", c), 64'(req_ready), 64'(1) << (c % N));
            @(posedge clk); #1;
            chk($sformatf("rr%0d_valid", c), 64'(rsp_valid), 64'h1);
            chk($sformatf("rr%0d_id", c), 64'(rsp_id), 64'(c % N));
        end

        // Randomized traffic against the reference model
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        m_hold = 0;
        m_data = '0;
        m_id   = 0;
        m_ptr  = 0;
        for (int c = 0; c < 400; c++) begin
            req_valid = '0;
            for (int i = 0; i < N; i++) begin
                int s;
                s = ($urandom_range(0, 7) == 0) ? 63 * int'($urandom_range(0, 1)) : int'($urandom_range(0, 63));
                set_req(i, {$urandom, $urandom}, s, int'($urandom_range(0, 3)));
            end
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            w = model_winner(req_valid, m_ptr);
            exp_ready = '0;
            if (w >= 0 && (!m_hold || rsp_ready)) exp_ready[w] = 1'b1;
            chk("rand_ready", 64'(req_ready), 64'(exp_ready));
            if (exp_ready != 0) begin
                m_hold = 1;
                m_data = model_shift(req_data[w*64 +: 64], int'(req_shamt[w*6 +: 6]), int'(req_op[w*2 +: 2]));
                m_id   = w;
                m_ptr  = (w + 1) % N;
            end else if (rsp_ready) begin
                m_hold = 0;
            end
            @(posedge clk); #1;
            chk("rand_valid", 64'(rsp_valid), 64'(m_hold));
            if (m_hold) begin
                chk("rand_data", rsp_data, m_data);
                chk("rand_id", 64'(rsp_id), 64'(m_id));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
